// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state encoding and prefetch-buffer entry type
// for the instruction fetch unit.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam int PC_STEP = 4;

  // FETCH: counting down the read latency or capturing.
  // STALL: latency elapsed but the prefetch buffer has no room.
  typedef enum logic {
    FETCH = 1'b0,
    STALL = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: show-ahead FIFO holding fetched {instr, pc} pairs.
//   clk, reset : clock and synchronous active-high reset
//   push       : write push_data (accepted when not full, or full with a pop)
//   push_data  : entry to write
//   pop        : remove the head (ignored when empty)
//   flush      : drop all entries; wins over push and pop
//   head       : current head entry, all zeros when empty
//   count      : number of valid entries
//   full/empty : occupancy flags
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int  BUF_DEPTH = 2,
  localparam int PTR_W     = $clog2(BUF_DEPTH),
  localparam int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  fetch_entry_t     mem [BUF_DEPTH];

  logic do_pop;
  logic do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(BUF_DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer still takes a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because BUF_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only visible through head, which
  // is forced to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential fetch unit. Holds the PC on Address, waits
// RD_LAT cycles, captures Data with its PC into a prefetch buffer and hands
// entries to decode over a valid/ready handshake.
//   CLK, Reset            : clock, synchronous active-high reset
//   Address               : registered fetch PC to instruction memory
//   Data                  : instruction word from memory
//   InstrValid/Instr/InstrPC : buffer head presented to decode
//   InstrReady            : decode accepts the head this cycle
//   Redirect/RedirectPC   : branch taken; flush and restart at RedirectPC
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int          RD_LAT    = 2,
  parameter int          BUF_DEPTH = 2,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [63:0] Address,
  input  logic [31:0] Data,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [63:0] InstrPC,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC
);

  localparam int         CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [3:0] LAST  = 4'(RD_LAT - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              capture;

  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_full;
  logic              buf_empty;
  logic              pop_req;
  logic              can_accept;
  logic [ADDR_W-1:0] redirect_aligned;

  assign pop_req          = !buf_empty && InstrReady;
  assign can_accept       = !buf_full || pop_req;
  assign redirect_aligned = RedirectPC & ~64'h3;
  assign push_entry       = '{instr: Data, pc: addr_q};

  // NOTE: every signal written here gets a default first so no latch is
  // inferred on paths that leave it untouched.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (Redirect) begin
      addr_d  = redirect_aligned;
      cnt_d   = '0;
      state_d = FETCH;
    end else if (cnt_q == LAST) begin
      // Latency elapsed: capture if there is room, otherwise hold Address
      // and the saturated count until the buffer drains.
      if (can_accept) begin
        capture = 1'b1;
        addr_d  = addr_q + ADDR_W'(PC_STEP);
        cnt_d   = '0;
        state_d = FETCH;
      end else begin
        state_d = STALL;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= FETCH;
      addr_q  <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Redirect flushes the buffer; a pop or capture on that edge is lost.
  fetch_buffer #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clk      (CLK),
    .reset    (Reset),
    .push     (capture),
    .push_data(push_entry),
    .pop      (pop_req),
    .flush    (Redirect),
    .head     (head),
    .count    (buf_count),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  assign Address    = addr_q;
  assign InstrValid = !buf_empty;
  assign Instr      = head.instr;
  assign InstrPC    = head.pc;

  occupancy_bound: assert property (@(posedge CLK) buf_count <= CNT_W'(BUF_DEPTH));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: main instance at RD_LAT=2 plus a
// second RD_LAT=1 instance exercised during the first streaming sequence.
module tb_instruction_fetch;

  localparam logic [31:0] WORD = 32'h8b020020;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] Address, Address1;
  logic [31:0] Data, Data1;
  logic        InstrValid, InstrValid1;
  logic [31:0] Instr, Instr1;
  logic [63:0] InstrPC, InstrPC1;
  logic        InstrReady;
  logic        Redirect;
  logic [63:0] RedirectPC;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  // Memory model: word at 0x0..0x10, zero elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a <= 64'h10) ? WORD : 32'h0;
  endfunction

  assign Data  = mem_word(Address);
  assign Data1 = mem_word(Address1);

  instruction_fetch #(.RD_LAT(2), .BUF_DEPTH(2), .RESET_PC(64'h0)) dut (
    .CLK(CLK), .Reset(Reset), .Address(Address), .Data(Data),
    .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC),
    .InstrReady(InstrReady), .Redirect(Redirect), .RedirectPC(RedirectPC)
  );

  instruction_fetch #(.RD_LAT(1), .BUF_DEPTH(2), .RESET_PC(64'h0)) dut1 (
    .CLK(CLK), .Reset(Reset), .Address(Address1), .Data(Data1),
    .InstrValid(InstrValid1), .Instr(Instr1), .InstrPC(InstrPC1),
    .InstrReady(1'b1), .Redirect(1'b0), .RedirectPC(64'h0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs and checks happen 1 ns later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reset sampled on one edge, deasserted before the next edge (E0).
  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 64'(InstrValid), 64'h0);
    check({tag, "_instr"}, 64'(Instr), 64'h0);
    check({tag, "_pc"}, InstrPC, 64'h0);
    check({tag, "_addr"}, Address, 64'h0);
  endtask

  initial begin
    Reset      = 1'b1;
    InstrReady = 1'b1;
    Redirect   = 1'b0;
    RedirectPC = 64'h0;
    step();

    // 1) Stream after reset, RD_LAT=2 main, RD_LAT=1 companion.
    do_reset();
    check_reset_vals("rst1");
    step();  // E0
    check("e0_valid", 64'(InstrValid), 64'h0);
    check("lat1_e0_pc", InstrPC1, 64'h0);
    check("lat1_e0_addr", Address1, 64'h4);
    for (int k = 0; k < 6; k++) begin
      step();  // odd edge: capture of PC 4k
      check($sformatf("stream_valid_%0d", k), 64'(InstrValid), 64'h1);
      check($sformatf("stream_pc_%0d", k), InstrPC, 64'(4 * k));
      check($sformatf("stream_instr_%0d", k), 64'(Instr), 64'(k <= 4 ? WORD : 32'h0));
      check($sformatf("stream_addr_%0d", k), Address, 64'(4 * k + 4));
      check($sformatf("lat1_pc_%0d", 2 * k + 1), InstrPC1, 64'(4 * (2 * k + 1)));
      step();  // even edge: head popped, next not yet captured
      check($sformatf("stream_gap_%0d", k), 64'(InstrValid), 64'h0);
      check($sformatf("lat1_valid_%0d", 2 * k + 2), 64'(InstrValid1), 64'h1);
      check($sformatf("lat1_pc_%0d", 2 * k + 2), InstrPC1, 64'(4 * (2 * k + 2)));
      check($sformatf("lat1_addr_%0d", 2 * k + 2), Address1, 64'(4 * (2 * k + 2) + 4));
    end

    // 2) Back-pressure for 10 cycles, then release.
    InstrReady = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    check("bp_valid", 64'(InstrValid), 64'h1);
    check("bp_head", InstrPC, 64'h0);
    check("bp_addr", Address, 64'h8);
    InstrReady = 1'b1;
    step();
    check("bp_rel_pc4", InstrPC, 64'h4);
    check("bp_rel_addr", Address, 64'hc);
    step();
    check("bp_rel_pc8", InstrPC, 64'h8);
    check("bp_rel_v8", 64'(InstrValid), 64'h1);
    step();
    check("bp_rel_pcc", InstrPC, 64'hc);

    // 3) Redirect to 0xC with a full buffer holding 0x0, 0x4.
    InstrReady = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check("pre_redir_head", InstrPC, 64'h0);
    Redirect   = 1'b1;
    RedirectPC = 64'hc;
    step();
    Redirect   = 1'b0;
    InstrReady = 1'b1;
    check("redir_valid", 64'(InstrValid), 64'h0);
    check("redir_addr", Address, 64'hc);
    check("redir_pc_zero", InstrPC, 64'h0);
    step();
    check("redir_wait", 64'(InstrValid), 64'h0);
    step();
    check("redir_first_v", 64'(InstrValid), 64'h1);
    check("redir_first_pc", InstrPC, 64'hc);
    check("redir_first_instr", 64'(Instr), 64'(WORD));
    step();
    check("redir_gap", 64'(InstrValid), 64'h0);
    step();
    check("redir_next_pc", InstrPC, 64'h10);

    // 4) Unaligned redirect with a coincident pop of 0x10.
    Redirect   = 1'b1;
    RedirectPC = 64'h13;
    step();
    Redirect = 1'b0;
    check("unal_addr", Address, 64'h10);
    check("unal_valid", 64'(InstrValid), 64'h0);
    step();
    check("unal_wait", 64'(InstrValid), 64'h0);
    step();
    check("unal_pc", InstrPC, 64'h10);
    check("unal_addr2", Address, 64'h14);

    // 5) Reset while stalled with a full buffer.
    InstrReady = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    check("stall_addr", Address, 64'h8);
    check("stall_valid", 64'(InstrValid), 64'h1);
    do_reset();
    check_reset_vals("rst2");
    InstrReady = 1'b1;
    step();
    check("rst2_e0", 64'(InstrValid), 64'h0);
    step();
    check("rst2_e1_valid", 64'(InstrValid), 64'h1);
    check("rst2_e1_pc", InstrPC, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Sequential fetch unit that drives the instruction memory read port and delivers instructions to decode.
- Holds the PC and presents it on `Address`.
- Waits a fixed read latency, then captures `Data` together with its PC into a small prefetch buffer.
- Hands buffered instructions to decode over a valid/ready handshake.
- Handles branch redirects and decode back-pressure.

## Interface
Parameters:
- `RD_LAT`, 2: cycles `Address` must be held stable before `Data` is sampled; legal range 1–15.
- `BUF_DEPTH`, 2: prefetch buffer entries; power of two, ≥2.
- `RESET_PC`, 64'h0: PC loaded on reset.

Ports:
- `CLK`  in  1  sole clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Address`  out  64  fetch PC to instruction memory; registered.
- `Data`  in  32  instruction word from memory; sampled only on capture cycles.
- `InstrValid`  out  1  buffer head holds a valid instruction.
- `Instr`  out  32  buffer head instruction word.
- `InstrPC`  out  64  PC of `Instr`.
- `InstrReady`  in  1  decode accepts the head this cycle.
- `Redirect`  in  1  branch taken; discard all fetched/in-flight work.
- `RedirectPC`  in  64  new fetch PC; bits [1:0] forced to 0.

## Operation
- Latency counter `cnt` (4 bits) counts cycles since `Address` last changed.
- Capture condition: `cnt == RD_LAT-1` and the buffer can accept an entry.
  - On capture: push {`Data`, `Address`}, `Address <= Address + 4` (64-bit wrap, no flag), `cnt <= 0`.
- Buffer can accept when it is not full, or when it is full and a pop occurs in the same cycle.
- Buffer full and no pop: FSM enters `STALL`.
  - `Address` and `cnt` are held, with `cnt` saturated at `RD_LAT-1`.
  - Capture fires on the first cycle the buffer can accept.
- FSM states:
  - `FETCH`: counting or capturing.
  - `STALL`: buffer full, waiting.
  - Transitions: `FETCH`→`STALL` when the capture condition holds but the buffer is full with no pop. `STALL`→`FETCH` on the capture cycle.
- Pop: `InstrValid && InstrReady` removes the head. Buffer is show-ahead, so `Instr`/`InstrPC` reflect the head combinationally from registered storage.
- Redirect has priority over everything:
  - Buffer count goes to 0 and all entries are invalidated.
  - `Address <= {RedirectPC[63:2],2'b00}`, `cnt <= 0`, FSM goes to `FETCH`.
  - A pop or capture in the redirect cycle is discarded; the handshake still completes from decode's view, and the instruction is lost by design.
- Reset has priority over Redirect.
- `Data` value 32'h0 is not special; it is delivered like any word.

## Timing
- Reset values:
  - `Address = RESET_PC`, `cnt = 0`, FSM `FETCH`, buffer empty.
  - `InstrValid = 0`, `Instr = 32'h0`, `InstrPC = 64'h0`.
  - `Instr` and `InstrPC` read 0 whenever the buffer is empty.
- Reset deasserts before edge E0. The first capture happens at edge E(RD_LAT-1), so `InstrValid` rises after edge E(RD_LAT-1) (RD_LAT=2: after E1).
- Steady-state throughput: one instruction per `RD_LAT` cycles (RD_LAT=1: one per cycle).
- Redirect sampled at edge E gives `InstrValid = 0` after E, and the first new instruction is valid after edge E+RD_LAT.
- Back-pressure: with `InstrReady` low, the buffer holds exactly `BUF_DEPTH` entries and `Address` points at the next unfetched PC.
- Simultaneous push and pop while full: count is unchanged and the FSM stays in `FETCH`.

## Structure
- Package `fetch_pkg`:
  - `INSTR_W = 32`, `ADDR_W = 64`, `PC_STEP = 4`.
  - FSM state enum {`FETCH`, `STALL`}.
  - Buffer entry typedef {instr, pc}.
- Sub-module `fetch_buffer`:
  - Show-ahead FIFO with parameter `BUF_DEPTH`.
  - Ports: push, push data, pop, flush, head, count, full, empty.
  - Synchronous `Reset`; flush has priority over push/pop.
- Top level contains the PC register, `cnt`, the FSM and the capture logic.

## Test plan
Memory model: holds `Address` stable for `RD_LAT`; 32'h8b020020 at 0x0–0x10, 0 elsewhere.
- Reset release, RD_LAT=2, `InstrReady=1` -> `InstrValid` rises after E1; PCs 0x0,0x4,0x8,0xc,0x10,0x14 delivered every 2 cycles; 0x14 carries `Instr=0`.
- RD_LAT=1, `InstrReady=1` -> one instruction per cycle; `Address` increments by 4 every edge.
- `InstrReady=0` for 10 cycles after reset -> buffer holds PCs 0x0,0x4; `Address=0x8` held. `InstrReady=1` -> 0x0,0x4,0x8 delivered in order with no gaps or duplicates.
- Redirect to 0x0C while the buffer holds 0x0,0x4 -> `InstrValid=0` the next cycle; next delivered PC is 0xC after RD_LAT cycles; 0x0/0x4 never reappear.
- Redirect with `RedirectPC=0x13` -> `Address=0x10`; a coincident pop is dropped.
- `Reset` asserted mid-stall with the buffer full -> next cycle matches all reset values; fetch restarts at `RESET_PC`.
